// File: rtl/sign_mag_pkg.sv
// ============================================================================
// Module   : sign_mag_pkg
// Purpose  : Opcodes and helpers shared by the sign-magnitude accumulator/ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sign_mag_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  // A zero magnitude always carries a positive sign.
  function automatic logic sm_normalize(input logic sign, input logic mag_is_zero);
    return sign & ~mag_is_zero;
  endfunction

endpackage : sign_mag_pkg

`default_nettype wire

// File: rtl/sign_mag_alu.sv
// ============================================================================
// Module   : sign_mag_alu
// Purpose  : Combinational saturating sign-magnitude adder, ACC_W-bit result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_mag_alu
  import sign_mag_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic             acc_sign_i,
  input  logic [ACC_W-2:0] acc_mag_i,
  input  logic             op_sign_i,
  input  logic [ACC_W-2:0] op_mag_i,
  output logic             res_sign_o,
  output logic [ACC_W-2:0] res_mag_o,
  output logic             sat_o
);

  localparam logic [ACC_W-2:0] MAXMAG = '1;

  logic [ACC_W-1:0] w_sum;
  logic             w_sign;
  logic [ACC_W-2:0] w_mag;

  assign w_sum = {1'b0, acc_mag_i} + {1'b0, op_mag_i};

  always_comb begin
    w_sign = 1'b0;
    w_mag  = '0;
    sat_o  = 1'b0;
    if (acc_sign_i == op_sign_i) begin
      w_sign = acc_sign_i;
      if (w_sum[ACC_W-1]) begin
        w_mag = MAXMAG;
        sat_o = 1'b1;
      end else begin
        w_mag = w_sum[ACC_W-2:0];
      end
    end else if (acc_mag_i > op_mag_i) begin
      w_sign = acc_sign_i;
      w_mag  = acc_mag_i - op_mag_i;
    end else if (op_mag_i > acc_mag_i) begin
      w_sign = op_sign_i;
      w_mag  = op_mag_i - acc_mag_i;
    end
  end

  assign res_mag_o  = w_mag;
  assign res_sign_o = sm_normalize(w_sign, w_mag == '0);

endmodule : sign_mag_alu

`default_nettype wire

// File: rtl/sign_mag_accum.sv
// ============================================================================
// Module   : sign_mag_accum
// Purpose  : Two-stage valid/ready sign-magnitude accumulator with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             ovf_sticky
);

  generate
    if (ACC_W < IN_W) begin : g_width_check
      $error("sign_mag_accum: ACC_W must be >= IN_W");
    end
  endgenerate

  // Stage 1: prepared operand
  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q,    s1_op_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [ACC_W-2:0] s1_mag_q,   s1_mag_d;

  // Stage 2: accumulator doubles as the output register
  logic             out_valid_q, out_valid_d;
  logic             acc_sign_q,  acc_sign_d;
  logic [ACC_W-2:0] acc_mag_q,   acc_mag_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             sticky_q,    sticky_d;

  logic             w_adv;
  logic             w_accept;
  op_t              w_in_op;
  logic [ACC_W-2:0] w_in_mag;
  logic             w_in_sign;
  logic             w_alu_sign;
  logic [ACC_W-2:0] w_alu_mag;
  logic             w_alu_sat;

  assign w_adv    = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || w_adv);
  assign w_accept = in_valid && in_ready;

  assign w_in_op   = op_t'(in_op);
  assign w_in_mag  = (ACC_W-1)'(in_data[IN_W-2:0]);
  // SUB is folded into an ADD of the negated operand.
  assign w_in_sign = sm_normalize(in_data[IN_W-1] ^ (w_in_op == OP_SUB), w_in_mag == '0);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = w_in_op;
      s1_sign_d  = w_in_sign;
      s1_mag_d   = w_in_mag;
    end else if (w_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  sign_mag_alu #(
    .ACC_W (ACC_W)
  ) u_alu (
    .acc_sign_i (acc_sign_q),
    .acc_mag_i  (acc_mag_q),
    .op_sign_i  (s1_sign_q),
    .op_mag_i   (s1_mag_q),
    .res_sign_o (w_alu_sign),
    .res_mag_o  (w_alu_mag),
    .sat_o      (w_alu_sat)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    acc_sign_d  = acc_sign_q;
    acc_mag_d   = acc_mag_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = sticky_q;
    if (w_adv) begin
      out_valid_d = 1'b1;
      case (s1_op_q)
        OP_ADD, OP_SUB: begin
          acc_sign_d = w_alu_sign;
          acc_mag_d  = w_alu_mag;
          out_ovf_d  = w_alu_sat;
          sticky_d   = sticky_q | w_alu_sat;
        end
        OP_LOAD: begin
          acc_sign_d = s1_sign_q;
          acc_mag_d  = s1_mag_q;
          out_ovf_d  = 1'b0;
        end
        default: begin
          acc_sign_d = 1'b0;
          acc_mag_d  = '0;
          out_ovf_d  = 1'b0;
          sticky_d   = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      out_valid_q <= 1'b0;
      acc_sign_q  <= 1'b0;
      acc_mag_q   <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      out_valid_q <= out_valid_d;
      acc_sign_q  <= acc_sign_d;
      acc_mag_q   <= acc_mag_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_acc    = {acc_sign_q, acc_mag_q};
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule : sign_mag_accum

`default_nettype wire

// File: tb/tb_sign_mag_accum.sv
// ============================================================================
// Module   : tb_sign_mag_accum
// Purpose  : Self-checking bench for sign_mag_accum against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_mag_accum;

  localparam int IN_W   = 8;
  localparam int ACC_W  = 12;
  localparam int MAXMAG = 2047;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             ovf_sticky;

  sign_mag_accum #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             sticky;
  } exp_t;

  int               n_pass  = 0;
  int               n_total = 0;
  exp_t             exp_q[$];
  logic [ACC_W-1:0] beat_log[$];
  int               m_acc    = 0;
  bit               m_sticky = 1'b0;
  logic [ACC_W-1:0] last_acc;
  logic             last_ovf;
  logic             last_sticky;
  bit               held_prev = 1'b0;
  logic [ACC_W-1:0] held_acc;
  logic             held_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain signed integer arithmetic clamped to +/-MAXMAG.
  task automatic model_apply(input logic [1:0] op, input logic [IN_W-1:0] d);
    int   mag;
    int   v;
    int   r;
    bit   ovf;
    exp_t e;
    mag = int'(d[IN_W-2:0]);
    v   = d[IN_W-1] ? -mag : mag;
    ovf = 1'b0;
    case (op)
      2'b00:   r = m_acc + v;
      2'b01:   r = m_acc - v;
      2'b10:   r = v;
      default: begin r = 0; m_sticky = 1'b0; end
    endcase
    if (r > MAXMAG)  begin r = MAXMAG;  ovf = 1'b1; end
    if (r < -MAXMAG) begin r = -MAXMAG; ovf = 1'b1; end
    if (ovf) m_sticky = 1'b1;
    m_acc    = r;
    e.acc    = (r < 0) ? {1'b1, 11'(-r)} : {1'b0, 11'(r)};
    e.ovf    = ovf;
    e.sticky = m_sticky;
    exp_q.push_back(e);
  endtask

  task automatic tick(output bit accepted);
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (held_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_acc",   32'(out_acc),   32'(held_acc));
      chk("hold_ovf",   32'(out_ovf),   32'(held_ovf));
    end
    if (rst) begin
      exp_q.delete();
      m_acc    = 0;
      m_sticky = 1'b0;
      held_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        model_apply(in_op, in_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_acc",    32'(out_acc),    32'(e.acc));
          chk("beat_ovf",    32'(out_ovf),    32'(e.ovf));
          chk("beat_sticky", 32'(ovf_sticky), 32'(e.sticky));
        end
        last_acc    = out_acc;
        last_ovf    = out_ovf;
        last_sticky = ovf_sticky;
        beat_log.push_back(out_acc);
      end
      held_prev = out_valid && !out_ready;
      held_acc  = out_acc;
      held_ovf  = out_ovf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [IN_W-1:0] d);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      tick(acc);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [1:0]      bp_op   [3];
  logic [IN_W-1:0] bp_data [3];

  initial begin
    bit acc;
    int k;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0; out_ready = 1'b1;
    tick(acc);
    tick(acc);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_out_acc",   32'(out_acc),    32'd0);
    chk("rst_out_ovf",   32'(out_ovf),    32'd0);
    chk("rst_sticky",    32'(ovf_sticky), 32'd0);
    chk("rst_in_ready",  32'(in_ready),   32'd0);
    rst = 1'b0;

    send(2'b10, 8'h15); send(2'b00, 8'hA8); drain();
    chk("mixed_sign_acc", 32'(last_acc), 32'h813);
    chk("mixed_sign_ovf", 32'(last_ovf), 32'd0);

    send(2'b10, 8'hEE); send(2'b00, 8'h66); drain();
    chk("neg_small_acc", 32'(last_acc), 32'h808);
    send(2'b11, 8'h00); send(2'b10, 8'hEE); send(2'b00, 8'hE6); drain();
    chk("neg_sum_acc", 32'(last_acc), 32'h8D4);

    send(2'b10, 8'h05); send(2'b01, 8'h05); drain();
    chk("sub_to_zero", 32'(last_acc), 32'h000);
    send(2'b10, 8'h80); drain();
    chk("load_neg_zero", 32'(last_acc), 32'h000);

    send(2'b10, 8'h7F);
    for (int i = 0; i < 15; i++) send(2'b00, 8'h7F);
    drain();
    chk("pre_sat_acc",    32'(last_acc),    32'h7F0);
    chk("pre_sat_sticky", 32'(last_sticky), 32'd0);
    send(2'b00, 8'h7F); drain();
    chk("sat_acc",    32'(last_acc),    32'h7FF);
    chk("sat_ovf",    32'(last_ovf),    32'd1);
    chk("sat_sticky", 32'(last_sticky), 32'd1);
    send(2'b00, 8'h81); drain();
    chk("post_sat_acc",    32'(last_acc),    32'h7FE);
    chk("post_sat_ovf",    32'(last_ovf),    32'd0);
    chk("post_sat_sticky", 32'(last_sticky), 32'd1);
    send(2'b11, 8'h00); drain();
    chk("clear_acc",    32'(last_acc),    32'h000);
    chk("clear_sticky", 32'(last_sticky), 32'd0);

    // Backpressure: three back-to-back ops against a stalled consumer
    bp_op[0] = 2'b10; bp_data[0] = 8'h01;
    bp_op[1] = 2'b00; bp_data[1] = 8'h02;
    bp_op[2] = 2'b00; bp_data[2] = 8'h03;
    beat_log.delete();
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1; in_op = bp_op[0]; in_data = bp_data[0];
    for (int c = 0; c < 5; c++) begin
      tick(acc);
      if (acc) begin
        k++;
        if (k < 3) begin in_op = bp_op[k]; in_data = bp_data[k]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(k),        32'd2);
    out_ready = 1'b1;
    n = 0;
    while ((k < 3 || exp_q.size() != 0 || out_valid) && n < 50) begin
      tick(acc);
      if (acc) begin k++; in_valid = 1'b0; end
      n++;
    end
    in_valid = 1'b0;
    chk("bp_beats", 32'(beat_log.size()), 32'd3);
    if (beat_log.size() == 3) begin
      chk("bp_beat0", 32'(beat_log[0]), 32'h001);
      chk("bp_beat1", 32'(beat_log[1]), 32'h003);
      chk("bp_beat2", 32'(beat_log[2]), 32'h006);
    end

    // Reset with both stages occupied and sticky set
    send(2'b10, 8'h7F);
    for (int i = 0; i < 16; i++) send(2'b00, 8'h7F);
    drain();
    chk("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
    out_ready = 1'b0;
    send(2'b10, 8'h05); send(2'b00, 8'h07);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    chk("mid_rst_valid",  32'(out_valid),  32'd0);
    chk("mid_rst_acc",    32'(out_acc),    32'd0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    out_ready = 1'b1;
    send(2'b00, 8'h03); drain();
    chk("post_rst_add", 32'(last_acc), 32'h003);

    // Randomized traffic with random consumer stalls
    for (int c = 0; c < 600; c++) begin
      int r;
      in_valid  = ($urandom_range(3) != 0);
      r         = $urandom_range(99);
      in_op     = (r < 6) ? 2'b11 : (r < 16) ? 2'b10 : (r < 60) ? 2'b00 : 2'b01;
      in_data   = IN_W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick(acc);
    end
    in_valid = 1'b0;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sign_mag_accum

`default_nettype wire
